branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Execute-stage consumer of the ALU comparator flags (EQ, signed LT, unsigned LT) in the RV32I core.
- Resolves conditional branches, JAL and JALR.
- Computes the actual next PC and the link value.
- Registers the result behind a one-entry valid/ready pipeline stage and raises a redirect toward fetch when the result disagrees with the fetch prediction.

Parameters:
- XLEN, 32, datapath width for PC, immediate, rs1, target and link.
- CNT_W, 16, performance counter width (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- flush_in  in  1  kill the in-flight and incoming op (younger-op flush from a later stage)
- in_valid  in  1  upstream op valid
- in_ready  out  1  stage can accept an op
- is_branch  in  1  conditional branch op
- is_jal  in  1  JAL op
- is_jalr  in  1  JALR op
- funct3  in  3  branch condition code
- eq  in  1  comparator EQ (rs1 == rs2)
- lt_s  in  1  signed rs1 < rs2
- lt_u  in  1  unsigned rs1 < rs2
- pc  in  XLEN  PC of the op
- imm  in  XLEN  sign-extended immediate
- rs1  in  XLEN  rs1 value (JALR base)
- pred_taken  in  1  fetch prediction for this op
- out_valid  out  1  registered result valid
- out_ready  in  1  downstream accepts the result
- taken  out  1  actual direction
- npc  out  XLEN  actual next PC
- link  out  XLEN  pc+4 for the rd write
- redirect  out  1  fetch must restart at npc
- misaligned  out  1  taken target is not 4-byte aligned
- illegal  out  1  branch with funct3 010 or 011

Behaviour:
- Reset (asynchronous, reset_n=0): out_valid=0, taken=0, npc=0, link=0, misaligned=0, illegal=0. redirect is 0 because it is gated by out_valid.
- Handshake: in_ready = !out_valid || out_ready. An op is accepted on an edge with in_valid && in_ready && !flush_in.
- At each edge:
  - Op accepted: out_valid<=1 and all result registers load. Latency is 1 cycle from accept to out_valid.
  - No op accepted and out_ready && out_valid: out_valid<=0.
  - Otherwise: all outputs hold. While out_valid && !out_ready, results must remain stable.
- Ops with none of is_branch/is_jal/is_jalr set are accepted and pass through with taken=0, npc=pc+4, redirect=0.
- Condition by funct3 (is_branch=1):
  - 000 BEQ → eq
  - 001 BNE → !eq
  - 100 BLT → lt_s
  - 101 BGE → !lt_s
  - 110 BLTU → lt_u
  - 111 BGEU → !lt_u
  - 010 or 011 → taken=0, illegal=1
- JAL and JALR: taken=1 regardless of the flags.
- Target:
  - Branch and JAL: pc+imm.
  - JALR: (rs1+imm) with bit 0 cleared.
  - All additions are modulo 2^XLEN; wrap-around is silent.
- npc = taken ? target : pc+4. link = pc+4, which wraps to 0 for pc=0xFFFFFFFC.
- misaligned = taken && (npc[1:0] != 0). The check is on npc after the JALR bit-0 clear, so in practice bit 1 triggers it.
- redirect = out_valid && !illegal && !misaligned && (taken != pred_taken).
  - Combinational from the registered state.
  - Asserted for every cycle out_valid is held, so fetch samples it on the accept edge.
- More than one of is_branch/is_jal/is_jalr set: priority is jalr, then jal, then branch.
- flush_in:
  - Takes priority over everything: the next edge sets out_valid<=0 and captures nothing.
  - in_ready is unaffected combinationally.
  - Result registers other than out_valid may keep stale data.
- Reset mid-operation: the op is dropped immediately, with no redirect pulse.

Optional Feature:
- Macro BRU_PERF_CNT_EN.
- When defined, adds two outputs, br_count [CNT_W] and mispred_count [CNT_W].
  - br_count counts accepted results (out_valid && out_ready) that are branch, JAL or JALR.
  - mispred_count counts those accepted results with redirect=1.
  - Both counters saturate at all-ones, reset to 0 asynchronously, and do not count flushed ops.
- When undefined, neither port exists and no counter logic is synthesized.

Test Plan:
- BEQ, pc=0x100, imm=0x20, eq=1, pred_taken=0 → 1 cycle later: out_valid=1, taken=1, npc=0x120, link=0x104, redirect=1.
- BGE, lt_s=1, pred_taken=0, pc=0x200 → taken=0, npc=0x204, redirect=0. BLTU with lt_u=1, pred_taken=1 → taken=1, redirect=0.
- JALR, rs1=0x1001, imm=0x4 → npc=0x1004, misaligned=0. rs1=0x1002, imm=0 → npc=0x1002, misaligned=1, redirect=0.
- funct3=010 → illegal=1, taken=0, redirect=0. pc=0xFFFFFFFC not taken → npc=0x0, link=0x0.
- Backpressure:
  - Hold out_ready=0 for 3 cycles → in_ready=0 and outputs stable.
  - Then out_ready=1 with a new in_valid → back-to-back accept, out_valid stays 1.
- flush_in during out_valid=1, plus reset_n pulsed low mid-transfer → out_valid=0 next edge (flush) or immediately (reset). With BRU_PERF_CNT_EN, counters are unchanged by the flush and read 0 after reset.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// Bundle of the op/result handshake signals for the branch resolve unit.
// The master drives ops and consumes results. The slave is the resolve stage.
interface branch_resolve_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic [2:0]      funct3;
    logic            eq;
    logic            lt_s;
    logic            lt_u;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
    logic            pred_taken;

    logic            out_valid;
    logic            out_ready;
    logic            taken;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] link;
    logic            redirect;
    logic            misaligned;
    logic            illegal;

    modport master (
        output in_valid, is_branch, is_jal, is_jalr, funct3, eq, lt_s, lt_u,
               pc, imm, rs1, pred_taken, out_ready,
        input  in_ready, out_valid, taken, npc, link, redirect, misaligned, illegal
    );

    modport slave (
        input  in_valid, is_branch, is_jal, is_jalr, funct3, eq, lt_s, lt_u,
               pc, imm, rs1, pred_taken, out_ready,
        output in_ready, out_valid, taken, npc, link, redirect, misaligned, illegal
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/JAL/JALR resolution behind a one-entry valid/ready register.
// Optional BRU_PERF_CNT_EN adds saturating control-flow and mispredict counters.
module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush_in,
    branch_resolve_unit_if.slave   bus
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]       br_count,
    output logic [CNT_W-1:0]       mispred_count
`endif
);

    logic            out_valid_q, out_valid_d;
    logic            taken_q, taken_d;
    logic [XLEN-1:0] npc_q, npc_d;
    logic [XLEN-1:0] link_q, link_d;
    logic            misaligned_q, misaligned_d;
    logic            illegal_q, illegal_d;
    logic            pred_taken_q, pred_taken_d;

    logic            accept;
    logic            taken_c;
    logic            illegal_c;
    logic            misaligned_c;
    logic [XLEN-1:0] link_c;
    logic [XLEN-1:0] target_c;
    logic [XLEN-1:0] jalr_sum_c;
    logic [XLEN-1:0] npc_c;

    assign bus.in_ready   = !out_valid_q || bus.out_ready;
    assign accept         = bus.in_valid && bus.in_ready && !flush_in;

    assign bus.out_valid  = out_valid_q;
    assign bus.taken      = taken_q;
    assign bus.npc        = npc_q;
    assign bus.link       = link_q;
    assign bus.misaligned = misaligned_q;
    assign bus.illegal    = illegal_q;
    assign bus.redirect   = out_valid_q && !illegal_q && !misaligned_q &&
                            (taken_q != pred_taken_q);

    // Op decode: jalr beats jal beats branch when several kind bits are set.
    always_comb begin
        link_c     = bus.pc + XLEN'(4);
        target_c   = bus.pc + bus.imm;
        jalr_sum_c = bus.rs1 + bus.imm;
        taken_c    = 1'b0;
        illegal_c  = 1'b0;
        if (bus.is_jalr) begin
            taken_c  = 1'b1;
            target_c = {jalr_sum_c[XLEN-1:1], 1'b0};
        end else if (bus.is_jal) begin
            taken_c = 1'b1;
        end else if (bus.is_branch) begin
            case (bus.funct3)
                3'b000:  taken_c = bus.eq;
                3'b001:  taken_c = !bus.eq;
                3'b100:  taken_c = bus.lt_s;
                3'b101:  taken_c = !bus.lt_s;
                3'b110:  taken_c = bus.lt_u;
                3'b111:  taken_c = !bus.lt_u;
                default: illegal_c = 1'b1;
            endcase
        end
        npc_c        = taken_c ? target_c : link_c;
        misaligned_c = taken_c && (npc_c[1:0] != 2'b00);
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        taken_d      = taken_q;
        npc_d        = npc_q;
        link_d       = link_q;
        misaligned_d = misaligned_q;
        illegal_d    = illegal_q;
        pred_taken_d = pred_taken_q;
        if (flush_in) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d  = 1'b1;
            taken_d      = taken_c;
            npc_d        = npc_c;
            link_d       = link_c;
            misaligned_d = misaligned_c;
            illegal_d    = illegal_c;
            pred_taken_d = bus.pred_taken;
        end else if (bus.out_ready && out_valid_q) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            taken_q      <= 1'b0;
            npc_q        <= '0;
            link_q       <= '0;
            misaligned_q <= 1'b0;
            illegal_q    <= 1'b0;
            pred_taken_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            taken_q      <= taken_d;
            npc_q        <= npc_d;
            link_q       <= link_d;
            misaligned_q <= misaligned_d;
            illegal_q    <= illegal_d;
            pred_taken_q <= pred_taken_d;
        end
    end

`ifdef BRU_PERF_CNT_EN
    logic             is_cf_q, is_cf_d;
    logic [CNT_W-1:0] br_count_q, br_count_d;
    logic [CNT_W-1:0] mispred_count_q, mispred_count_d;
    logic             result_taken;

    // A result counts only when it leaves the stage and is not being flushed.
    assign result_taken  = out_valid_q && bus.out_ready && !flush_in && is_cf_q;
    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

    always_comb begin
        is_cf_d         = is_cf_q;
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (accept) begin
            is_cf_d = bus.is_branch || bus.is_jal || bus.is_jalr;
        end
        if (result_taken && (br_count_q != '1)) begin
            br_count_d = br_count_q + CNT_W'(1);
        end
        if (result_taken && bus.redirect && (mispred_count_q != '1)) begin
            mispred_count_d = mispred_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            is_cf_q         <= 1'b0;
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            is_cf_q         <= is_cf_d;
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus a
// randomized run against a behavioural model of the one-entry result stage.
module tb_branch_resolve_unit;

    typedef struct {
        logic        taken;
        logic [31:0] npc;
        logic [31:0] link;
        logic        mis;
        logic        ill;
        logic        redir;
        logic        cf;
    } res_t;

    logic clk;
    logic reset_n;
    logic flush_in;
    int   total;
    int   bad;

    branch_resolve_unit_if #(.XLEN(32)) bus ();

`ifdef BRU_PERF_CNT_EN
    logic [15:0] br_count;
    logic [15:0] mispred_count;
`endif

    branch_resolve_unit #(.XLEN(32), .CNT_W(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .flush_in      (flush_in),
        .bus           (bus)
`ifdef BRU_PERF_CNT_EN
        ,
        .br_count      (br_count),
        .mispred_count (mispred_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: architectural meaning of each op, written from the ISA rules.
    function automatic res_t ref_model(input logic b, input logic j, input logic jr,
                                       input logic [2:0] f3, input logic e,
                                       input logic ls, input logic lu,
                                       input logic [31:0] pc, input logic [31:0] imm,
                                       input logic [31:0] rs1, input logic pred);
        res_t        r;
        longint      sum;
        logic [31:0] tgt;
        r.ill   = 1'b0;
        r.taken = 1'b0;
        r.cf    = b | j | jr;
        sum     = (longint'(pc) + longint'(imm)) % 64'h1_0000_0000;
        tgt     = 32'(sum);
        if (jr) begin
            sum     = (longint'(rs1) + longint'(imm)) % 64'h1_0000_0000;
            tgt     = 32'((sum / 2) * 2);
            r.taken = 1'b1;
        end else if (j) begin
            r.taken = 1'b1;
        end else if (b) begin
            if (f3 == 3'd0)      r.taken = e;
            else if (f3 == 3'd1) r.taken = !e;
            else if (f3 == 3'd4) r.taken = ls;
            else if (f3 == 3'd5) r.taken = !ls;
            else if (f3 == 3'd6) r.taken = lu;
            else if (f3 == 3'd7) r.taken = !lu;
            else                 r.ill   = 1'b1;
        end
        r.link  = 32'((longint'(pc) + 4) % 64'h1_0000_0000);
        r.npc   = r.taken ? tgt : r.link;
        r.mis   = r.taken && ((r.npc % 4) != 0);
        r.redir = !r.ill && !r.mis && (r.taken != pred);
        return r;
    endfunction

    task automatic drive_op(input logic b, input logic j, input logic jr,
                            input logic [2:0] f3, input logic e, input logic ls,
                            input logic lu, input logic [31:0] pc,
                            input logic [31:0] imm, input logic [31:0] rs1,
                            input logic pred);
        bus.in_valid   = 1'b1;
        bus.is_branch  = b;
        bus.is_jal     = j;
        bus.is_jalr    = jr;
        bus.funct3     = f3;
        bus.eq         = e;
        bus.lt_s       = ls;
        bus.lt_u       = lu;
        bus.pc         = pc;
        bus.imm        = imm;
        bus.rs1        = rs1;
        bus.pred_taken = pred;
    endtask

    task automatic go_idle();
        drive_op(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        bus.in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        go_idle();
        flush_in      = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        flush_in = 1'b0;
        bus.out_ready = 1'b1;
        go_idle();
        #12;
        total++;
        if ({bus.out_valid, bus.taken, bus.misaligned, bus.illegal, bus.redirect} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags got=%b exp=00000",
                     {bus.out_valid, bus.taken, bus.misaligned, bus.illegal, bus.redirect});
        end
        total++;
        if ({bus.npc, bus.link} !== 64'h0) begin
            bad++;
            $display("[TB] FAIL reset_npc_link got=%h/%h exp=0/0", bus.npc, bus.link);
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
`ifdef BRU_PERF_CNT_EN
        total++;
        if ({br_count, mispred_count} !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_counts got=%0d/%0d exp=0/0", br_count, mispred_count);
        end
`endif
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_branches();
        @(negedge clk);
        drive_op(1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h100, 32'h20, 32'h0, 1'b0);
        tick();
        total++;
        if ({bus.out_valid, bus.taken, bus.redirect, bus.npc, bus.link} !== {3'b111, 32'h120, 32'h104}) begin
            bad++;
            $display("[TB] FAIL beq got v/t/r=%b%b%b npc=%h link=%h exp 111 npc=120 link=104",
                     bus.out_valid, bus.taken, bus.redirect, bus.npc, bus.link);
        end
        @(negedge clk);
        drive_op(1'b1, 1'b0, 1'b0, 3'b101, 1'b0, 1'b1, 1'b0, 32'h200, 32'h40, 32'h0, 1'b0);
        tick();
        total++;
        if ({bus.out_valid, bus.taken, bus.redirect, bus.npc} !== {3'b100, 32'h204}) begin
            bad++;
            $display("[TB] FAIL bge got v/t/r=%b%b%b npc=%h exp 100 npc=204",
                     bus.out_valid, bus.taken, bus.redirect, bus.npc);
        end
        @(negedge clk);
        drive_op(1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 1'b1, 32'h300, 32'h8, 32'h0, 1'b1);
        tick();
        total++;
        if ({bus.out_valid, bus.taken, bus.redirect, bus.npc} !== {3'b110, 32'h308}) begin
            bad++;
            $display("[TB] FAIL bltu got v/t/r=%b%b%b npc=%h exp 110 npc=308",
                     bus.out_valid, bus.taken, bus.redirect, bus.npc);
        end
    endtask

    task automatic test_jalr();
        @(negedge clk);
        drive_op(1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h40, 32'h4, 32'h1001, 1'b1);
        tick();
        total++;
        if ({bus.taken, bus.misaligned, bus.redirect, bus.npc, bus.link} !== {3'b100, 32'h1004, 32'h44}) begin
            bad++;
            $display("[TB] FAIL jalr_aligned got t/m/r=%b%b%b npc=%h link=%h exp 100 npc=1004 link=44",
                     bus.taken, bus.misaligned, bus.redirect, bus.npc, bus.link);
        end
        @(negedge clk);
        drive_op(1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h80, 32'h0, 32'h1002, 1'b0);
        tick();
        total++;
        if ({bus.taken, bus.misaligned, bus.redirect, bus.npc} !== {3'b110, 32'h1002}) begin
            bad++;
            $display("[TB] FAIL jalr_misaligned got t/m/r=%b%b%b npc=%h exp 110 npc=1002",
                     bus.taken, bus.misaligned, bus.redirect, bus.npc);
        end
    endtask

    task automatic test_illegal_wrap();
        @(negedge clk);
        drive_op(1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 1'b1, 1'b1, 32'h400, 32'h10, 32'h0, 1'b1);
        tick();
        total++;
        if ({bus.illegal, bus.taken, bus.redirect, bus.npc} !== {3'b100, 32'h404}) begin
            bad++;
            $display("[TB] FAIL illegal got i/t/r=%b%b%b npc=%h exp 100 npc=404",
                     bus.illegal, bus.taken, bus.redirect, bus.npc);
        end
        @(negedge clk);
        drive_op(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h8, 32'h0, 1'b0);
        tick();
        total++;
        if ({bus.illegal, bus.taken, bus.redirect, bus.npc, bus.link} !== {3'b000, 32'h0, 32'h0}) begin
            bad++;
            $display("[TB] FAIL pc_wrap got i/t/r=%b%b%b npc=%h link=%h exp 000 npc=0 link=0",
                     bus.illegal, bus.taken, bus.redirect, bus.npc, bus.link);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive_op(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h500, 32'h100, 32'h0, 1'b0);
        tick();
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive_op(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h700, 32'h10, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({bus.in_ready, bus.out_valid, bus.taken, bus.redirect, bus.npc, bus.link} !==
                {4'b0111, 32'h600, 32'h504}) begin
                bad++;
                $display("[TB] FAIL stall_hold cycle=%0d got rdy/v/t/r=%b%b%b%b npc=%h link=%h exp 0111 npc=600 link=504",
                         i, bus.in_ready, bus.out_valid, bus.taken, bus.redirect, bus.npc, bus.link);
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        tick();
        total++;
        if ({bus.out_valid, bus.taken, bus.redirect, bus.npc} !== {3'b100, 32'h704}) begin
            bad++;
            $display("[TB] FAIL b2b_accept got v/t/r=%b%b%b npc=%h exp 100 npc=704",
                     bus.out_valid, bus.taken, bus.redirect, bus.npc);
        end
    endtask

    task automatic test_flush();
`ifdef BRU_PERF_CNT_EN
        logic [15:0] br_before;
`endif
        @(negedge clk);
        drive_op(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h800, 32'h20, 32'h0, 1'b0);
        tick();
        @(negedge clk);
        flush_in = 1'b1;
        drive_op(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h900, 32'h20, 32'h0, 1'b0);
        #1;
`ifdef BRU_PERF_CNT_EN
        br_before = br_count;
`endif
        total++;
        if ({bus.in_ready, bus.out_valid} !== 2'b11) begin
            bad++;
            $display("[TB] FAIL flush_in_ready got rdy/v=%b%b exp 11", bus.in_ready, bus.out_valid);
        end
        tick();
        total++;
        if ({bus.out_valid, bus.redirect} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL flush_drop got v/r=%b%b exp 00", bus.out_valid, bus.redirect);
        end
`ifdef BRU_PERF_CNT_EN
        total++;
        if (br_count !== br_before) begin
            bad++;
            $display("[TB] FAIL flush_count got=%0d exp=%0d", br_count, br_before);
        end
`endif
        @(negedge clk);
        flush_in = 1'b0;
        drive_op(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'hA00, 32'h20, 32'h0, 1'b0);
        tick();
        go_idle();
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({bus.out_valid, bus.redirect, bus.npc} !== {2'b00, 32'h0}) begin
            bad++;
            $display("[TB] FAIL reset_mid got v/r=%b%b npc=%h exp 00 npc=0",
                     bus.out_valid, bus.redirect, bus.npc);
        end
`ifdef BRU_PERF_CNT_EN
        total++;
        if ({br_count, mispred_count} !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_mid_counts got=%0d/%0d exp=0/0", br_count, mispred_count);
        end
`endif
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        logic        ev;
        res_t        er;
        res_t        nr;
        logic        exp_rdy;
        logic        acc;
        logic [31:0] pc;
        logic [31:0] imm;
        int          brc;
        int          mpc;
        do_reset();
        ev  = 1'b0;
        er  = ref_model(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        brc = 0;
        mpc = 0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            pc  = {$urandom_range(0, 15) == 0 ? 30'h3FFF_FFFF : 30'($urandom), 2'b00};
            imm = ($urandom_range(0, 3) == 0) ? $urandom : 32'(int'($urandom_range(0, 4096)) - 2048);
            drive_op(1'($urandom), 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
                     3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     pc, imm, $urandom, 1'($urandom));
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            flush_in      = ($urandom_range(0, 15) == 0);
            nr = ref_model(bus.is_branch, bus.is_jal, bus.is_jalr, bus.funct3, bus.eq,
                           bus.lt_s, bus.lt_u, bus.pc, bus.imm, bus.rs1, bus.pred_taken);
            exp_rdy = !ev || bus.out_ready;
            acc     = bus.in_valid && exp_rdy && !flush_in;
            #1;
            total++;
            if (bus.in_ready !== exp_rdy) begin
                bad++;
                $display("[TB] FAIL rand_in_ready n=%0d got=%b exp=%b", n, bus.in_ready, exp_rdy);
            end
            if (ev && bus.out_ready && !flush_in && er.cf) begin
                brc++;
                if (er.redir) mpc++;
            end
            if (flush_in) ev = 1'b0;
            else if (acc) begin
                ev = 1'b1;
                er = nr;
            end else if (bus.out_ready && ev) ev = 1'b0;
            tick();
            total++;
            if (bus.out_valid !== ev) begin
                bad++;
                $display("[TB] FAIL rand_valid n=%0d got=%b exp=%b", n, bus.out_valid, ev);
            end else if (ev) begin
                total++;
                if ({bus.taken, bus.npc, bus.link, bus.misaligned, bus.illegal, bus.redirect} !==
                    {er.taken, er.npc, er.link, er.mis, er.ill, er.redir}) begin
                    bad++;
                    $display("[TB] FAIL rand_result n=%0d got t=%b npc=%h link=%h m=%b i=%b r=%b exp t=%b npc=%h link=%h m=%b i=%b r=%b",
                             n, bus.taken, bus.npc, bus.link, bus.misaligned, bus.illegal, bus.redirect,
                             er.taken, er.npc, er.link, er.mis, er.ill, er.redir);
                end
            end else begin
                total++;
                if (bus.redirect !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL rand_redirect_idle n=%0d got=%b exp=0", n, bus.redirect);
                end
            end
`ifdef BRU_PERF_CNT_EN
            total++;
            if ({br_count, mispred_count} !== {16'(brc), 16'(mpc)}) begin
                bad++;
                $display("[TB] FAIL rand_counts n=%0d got=%0d/%0d exp=%0d/%0d",
                         n, br_count, mispred_count, brc, mpc);
            end
`endif
        end
        @(negedge clk);
        go_idle();
        flush_in = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_branches();
        test_jalr();
        test_illegal_wrap();
        test_back_to_back();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
